// File: rtl/rand_range_picker_if.sv
`default_nettype none
// ============================================================================
// Module   : rand_range_picker_if
// Brief    : Request/response and LFSR-side signals of the range picker.
// Revision : 1.0
// ============================================================================
interface rand_range_picker_if;
    logic       req;
    logic [7:0] range;
    logic [7:0] rng_value;
    logic       rng_step;
    logic       busy;
    logic       valid;
    logic [7:0] value;

    modport master (
        output req, range, rng_value,
        input  rng_step, busy, valid, value
    );

    modport slave (
        input  req, range, rng_value,
        output rng_step, busy, valid, value
    );
endinterface
`default_nettype wire

// File: rtl/rand_range_picker.sv
`default_nettype none
// ============================================================================
// Module   : rand_range_picker
// Brief    : Steps an 8-bit LFSR on request and reduces the byte modulo N,
//            optionally re-rolling picks that repeat the previous delivery.
// Revision : 1.0
// ============================================================================
module rand_range_picker #(
    parameter bit NO_REPEAT = 1'b1,
    parameter int MAX_RETRY = 3
) (
    input  logic               clock,
    input  logic               reset,
    rand_range_picker_if.slave bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] STEP   = 3'd1;
    localparam logic [2:0] SAMPLE = 3'd2;
    localparam logic [2:0] REDUCE = 3'd3;
    localparam logic [2:0] CHECK  = 3'd4;

    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    logic [2:0] state;
    logic [7:0] lim;
    logic [7:0] rem;
    logic [7:0] last;
    logic       last_valid;
    logic [2:0] retry;
    logic       repeat_hit;

    assign repeat_hit = NO_REPEAT && last_valid && (rem == last) && (retry < RETRY_LIMIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            lim          <= 8'd0;
            rem          <= 8'd0;
            last         <= 8'd0;
            last_valid   <= 1'b0;
            retry        <= 3'd0;
            bus.rng_step <= 1'b0;
            bus.busy     <= 1'b0;
            bus.valid    <= 1'b0;
            bus.value    <= 8'd0;
        end else begin
            bus.valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        if (bus.range >= 8'd2) begin
                            lim          <= bus.range;
                            retry        <= 3'd0;
                            bus.rng_step <= 1'b1;
                            bus.busy     <= 1'b1;
                            state        <= STEP;
                        end else begin
                            // Zero or one choice: answer is 0 without touching the LFSR
                            bus.value  <= 8'd0;
                            bus.valid  <= 1'b1;
                            last       <= 8'd0;
                            last_valid <= 1'b1;
                        end
                    end
                end
                STEP: begin
                    bus.rng_step <= 1'b0;
                    state        <= SAMPLE;
                end
                SAMPLE: begin
                    rem   <= bus.rng_value;
                    state <= REDUCE;
                end
                REDUCE: begin
                    if (rem >= lim) begin
                        rem <= rem - lim;
                    end else begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (repeat_hit) begin
                        retry        <= retry + 3'd1;
                        bus.rng_step <= 1'b1;
                        state        <= STEP;
                    end else begin
                        bus.value  <= rem;
                        last       <= rem;
                        last_valid <= 1'b1;
                        bus.valid  <= 1'b1;
                        bus.busy   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    bus.rng_step <= 1'b0;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rand_range_picker.sv
`default_nettype none
// ============================================================================
// Module   : tb_rand_range_picker
// Brief    : Vector table plus scoreboard bench for rand_range_picker.
// Revision : 1.0
// ============================================================================
module tb_rand_range_picker;

    logic clock = 1'b0;
    logic reset = 1'b0;

    rand_range_picker_if ifc();

    rand_range_picker #(.NO_REPEAT(1'b1), .MAX_RETRY(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] range;
        int         n_stub;
        logic [7:0] stub [4];
        logic [7:0] exp_value;
        int         exp_steps;
    } vec_t;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         step_cnt = 0;
    logic       prev_step = 1'b0;
    logic       use_lfsr = 1'b0;
    logic [7:0] stub_q [$];
    logic [7:0] sb_q [$];

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // LFSR stand-in: advances on the registered step pulse
    initial ifc.rng_value = 8'h00;
    always @(posedge clock) begin
        if (ifc.rng_step) begin
            if (use_lfsr)
                ifc.rng_value <= lfsr_next(ifc.rng_value);
            else if (stub_q.size() > 0)
                ifc.rng_value <= stub_q.pop_front();
        end
    end

    // Output monitor: scoreboard pop plus pulse invariants
    always @(negedge clock) begin
        if (reset) begin
            if (ifc.rng_step) begin
                chk("step_single_cycle", int'(prev_step), 0);
                if (!prev_step) step_cnt++;
            end
            if (ifc.valid) begin
                chk("no_step_on_valid", int'(ifc.rng_step), 0);
                chk("busy_low_on_valid", int'(ifc.busy), 0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    chk("value", int'(ifc.value), int'(sb_q.pop_front()));
                end
            end
        end
        prev_step = ifc.rng_step;
    end

    task automatic run_vec(input vec_t v, input int idx);
        int exp_lat;
        int s0;
        int n;
        exp_lat = 0;
        for (int i = 0; i < v.n_stub; i++) begin
            stub_q.push_back(v.stub[i]);
            exp_lat += 4 + int'(v.stub[i]) / int'(v.range);
        end
        sb_q.push_back(v.exp_value);
        s0 = step_cnt;
        @(negedge clock);
        ifc.req   = 1'b1;
        ifc.range = v.range;
        @(posedge clock);
        #1;
        ifc.req   = 1'b0;
        ifc.range = 8'hAA;
        @(negedge clock);
        n = 0;
        while (!ifc.valid && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk($sformatf("vec%0d_timeout", idx), int'(ifc.valid), 1);
        chk($sformatf("vec%0d_latency", idx), n, exp_lat);
        chk($sformatf("vec%0d_steps", idx), step_cnt - s0, v.exp_steps);
    endtask

    vec_t vecs [12];

    initial begin
        logic [7:0] s;
        logic [7:0] last_m;
        int         retry_m;
        int         model_steps;
        int         s0;
        int         cnt;
        int         cyc;
        logic [7:0] r;

        vecs[0]  = '{8'd10,  1, '{8'h1E, 8'h00, 8'h00, 8'h00}, 8'd0,   1};
        vecs[1]  = '{8'd1,   0, '{8'h00, 8'h00, 8'h00, 8'h00}, 8'd0,   0};
        vecs[2]  = '{8'd0,   0, '{8'h00, 8'h00, 8'h00, 8'h00}, 8'd0,   0};
        vecs[3]  = '{8'd4,   1, '{8'h06, 8'h00, 8'h00, 8'h00}, 8'd2,   1};
        vecs[4]  = '{8'd4,   2, '{8'h0A, 8'h0B, 8'h00, 8'h00}, 8'd3,   2};
        vecs[5]  = '{8'd4,   1, '{8'h02, 8'h00, 8'h00, 8'h00}, 8'd2,   1};
        vecs[6]  = '{8'd4,   4, '{8'h02, 8'h02, 8'h02, 8'h02}, 8'd2,   4};
        vecs[7]  = '{8'd2,   1, '{8'hFF, 8'h00, 8'h00, 8'h00}, 8'd1,   1};
        vecs[8]  = '{8'd255, 1, '{8'hFE, 8'h00, 8'h00, 8'h00}, 8'd254, 1};
        vecs[9]  = '{8'd255, 1, '{8'hFF, 8'h00, 8'h00, 8'h00}, 8'd0,   1};
        vecs[10] = '{8'd200, 2, '{8'h00, 8'h07, 8'h00, 8'h00}, 8'd7,   2};
        vecs[11] = '{8'd8,   4, '{8'h07, 8'h0F, 8'h17, 8'h1F}, 8'd7,   4};

        ifc.req   = 1'b0;
        ifc.range = 8'd0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_rng_step", int'(ifc.rng_step), 0);
        chk("rst_busy", int'(ifc.busy), 0);
        chk("rst_valid", int'(ifc.valid), 0);
        chk("rst_value", int'(ifc.value), 0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Asynchronous reset in the middle of a long reduction
        stub_q.push_back(8'hFF);
        @(negedge clock);
        ifc.req   = 1'b1;
        ifc.range = 8'd2;
        @(posedge clock);
        #1;
        ifc.req = 1'b0;
        repeat (10) @(negedge clock);
        chk("mid_busy", int'(ifc.busy), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_rng_step", int'(ifc.rng_step), 0);
        chk("arst_busy", int'(ifc.busy), 0);
        chk("arst_valid", int'(ifc.valid), 0);
        chk("arst_value", int'(ifc.value), 0);
        stub_q.delete();
        @(negedge clock);
        #2;
        reset = 1'b1;
        run_vec(vecs[0], 100);

        // Back-to-back picks from a real LFSR with req held high
        s           = ifc.rng_value;
        last_m      = 8'd0;
        model_steps = 0;
        for (int p = 0; p < 12; p++) begin
            retry_m = 0;
            forever begin
                s = lfsr_next(s);
                model_steps++;
                r = s % 8'd7;
                if (r == last_m && retry_m < 3) retry_m++;
                else break;
            end
            sb_q.push_back(r);
            last_m = r;
        end
        use_lfsr = 1'b1;
        s0 = step_cnt;
        @(negedge clock);
        ifc.req   = 1'b1;
        ifc.range = 8'd7;
        cnt = 0;
        cyc = 0;
        while (cnt < 12 && cyc < 20000) begin
            @(negedge clock);
            cyc++;
            if (ifc.valid) cnt++;
        end
        ifc.req = 1'b0;
        chk("lfsr_picks", cnt, 12);
        chk("lfsr_steps", step_cnt - s0, model_steps);
        repeat (20) @(negedge clock);
        chk("idle_steps", step_cnt - s0, model_steps);
        chk("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rand_range_picker.md
Name: rand_range_picker

Overview:
- Consumer stage for the 8-bit LFSR random source.
- On request, steps the LFSR once via a registered enable pulse, captures the new byte, and reduces it modulo a caller-supplied range by iterative subtraction.
- Optionally rejects a pick equal to the previous one, re-stepping the LFSR up to a bounded retry count.
- Game logic uses it for spawn positions and lane choices; presents the result with a one-cycle valid pulse.

Parameters:
- NO_REPEAT, 1, 1 = reject a pick equal to the last delivered value; 0 = accept any pick.
- MAX_RETRY, 3, maximum re-rolls per request before the repeated value is accepted (1..7).

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  request a pick; sampled only in IDLE.
- range  input  8  number of choices N; latched when req is accepted.
- rng_value  input  8  current LFSR output byte.
- rng_step  output  1  registered step pulse to the LFSR enable; glitch-free.
- busy  output  1  high while a request is in progress.
- valid  output  1  one-cycle pulse: value is the new pick.
- value  output  8  last delivered pick, in 0..N-1; held between picks.

Behaviour:
- Reset (async, reset low): state IDLE; rng_step 0, busy 0, valid 0, value 0, last_valid 0, retry count 0. Takes effect immediately, including mid-request. No partial result is delivered.
- rng_step, busy and valid are flops, not decodes. rng_step must never glitch, because the LFSR steps on its rising edge.
- States: IDLE, STEP, SAMPLE, REDUCE, CHECK.
- IDLE, req=1, range>=2 (edge E0):
  - lim <= range, retry <= 0, rng_step <= 1, busy <= 1, state <= STEP.
- IDLE, req=1, range<=1:
  - No LFSR step.
  - At E0: value <= 0, valid <= 1, last <= 0, last_valid <= 1; stay IDLE.
- STEP (E1): rng_step <= 0, state <= SAMPLE. The LFSR has advanced by E1.
- SAMPLE (E2): rem <= rng_value, state <= REDUCE.
- REDUCE, each edge:
  - If rem >= lim: rem <= rem - lim (8-bit unsigned, never underflows).
  - Else: state <= CHECK.
  - One subtraction per cycle; k = floor(rng_value / lim); worst case 127 cycles (lim=2, rem=255).
- CHECK, repeat condition = NO_REPEAT=1 and last_valid=1 and rem==last and retry<MAX_RETRY:
  - Repeat: retry <= retry+1, rng_step <= 1, state <= STEP.
  - Otherwise: value <= rem, last <= rem, last_valid <= 1, valid <= 1, busy <= 0, state <= IDLE.
- Latency, no retry: valid is high in the cycle after edge E(4+k). Each retry adds 4+k' cycles.
- Retry exhaustion: after MAX_RETRY re-rolls the repeated value is delivered anyway.
- valid is high exactly one cycle. value holds until the next delivery or reset.
- req while busy=1: ignored, not queued.
- req in the cycle valid=1: accepted, because the state is already IDLE.
- range changes after acceptance: ignored; lim is latched.
- rng_step is asserted exactly once per STEP entry and is never held high for 2 cycles.

Test Plan:
- Reset mid-REDUCE with reset low for 1 cycle -> rng_step, busy, valid, value all 0 immediately. A following req with range=10 and stub rng 0x1E behaves as the first pick ever (last_valid=0).
- range=10, stub rng_value 0x1E after step -> one rng_step pulse; three subtractions (30→20→10→0); valid high in the cycle after E7 with value=0x00; busy low in that same cycle.
- range=1, then range=0 -> no rng_step pulse; valid in the cycle after E0 with value=0 for each.
- NO_REPEAT=1, range=4: first pick from rng 0x06 gives 2. Second request with stub sequence 0x0A then 0x0B -> two rng_step pulses; value=3; one retry used.
- NO_REPEAT=1, MAX_RETRY=3, range=4, stub always 0x02 after a prior pick of 2 -> exactly 4 rng_step pulses; value=2 delivered.
- req held high continuously with a real LFSR model, range=7 -> back-to-back picks with no dropped or double pulses. Every value < 7; no rng_step while valid=1; req during busy never starts a second step.
